// File: rtl/bus_pkg.sv
// Shared widths, FSM state encoding and din synchroniser latency for bus_pin_ctrl.
// SYNC_LAT follows BUS_DIN_SYNC_EN.
package bus_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 4;

`ifdef BUS_DIN_SYNC_EN
  localparam int unsigned SYNC_LAT = 2;
`else
  localparam int unsigned SYNC_LAT = 0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/din_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous input pins.
module din_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bus_pin_ctrl.sv
// Single-transaction bus unit between the CPU core and the external pins.
// Define BUS_DIN_SYNC_EN to route pin_din through a 2-flop synchroniser.
module bus_pin_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] pin_addr,
  output logic              pin_rw,
  output logic [DATA_W-1:0] pin_dout,
  output logic [DATA_W-1:0] pin_oe,
  input  logic [DATA_W-1:0] pin_din
);

  localparam logic [4:0] CNT_LOAD = 5'(WAIT_CYCLES + SYNC_LAT);

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              we_q;
  logic              load;
  logic              capture;
  logic [DATA_W-1:0] din_s;

`ifdef BUS_DIN_SYNC_EN
  din_sync #(.WIDTH(DATA_W)) u_din_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pin_din),
    .q     (din_s)
  );
`else
  assign din_s = pin_din;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          load    = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
        end else begin
          capture = ~we_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_addr  <= '0;
      pin_dout  <= '0;
      we_q      <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      if (load) begin
        pin_addr <= cpu_addr;
        pin_dout <= cpu_wdata;
        we_q     <= cpu_we;
      end
      if (capture) begin
        cpu_rdata <= din_s;
      end
    end
  end

  // Direction is decoded from state so reset releases the pins without waiting for a clock.
  assign pin_rw    = (state_q != IDLE) && we_q;
  assign pin_oe    = {DATA_W{pin_rw}};
  assign cpu_ready = (state_q == DONE);

endmodule
